display_timings: RTL and testbench



---
 rtl/display_timings.sv | 103 ++++++++++
 tb/tb_display_timings.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/display_timings.sv
// Raster timing generator for the pixel-clock domain: counters, syncs, data enable, line/frame strobes.
// Optional DISPLAY_TIMINGS_FRAME_COUNT_EN adds a 16-bit frame counter output.
module display_timings #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter logic        H_POL  = 1'b0,
    parameter logic        V_POL  = 1'b0,
    parameter int unsigned CORDW  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic [CORDW-1:0] o_sx,
    output logic [CORDW-1:0] o_sy,
    output logic             o_line,
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    output logic [15:0]      o_frame_cnt,
`endif
    output logic             o_frame
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST     = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST     = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT      = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT      = CORDW'(V_RES);
    localparam logic [CORDW-1:0] H_SYNC_STA = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] H_SYNC_END = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] V_SYNC_STA = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] V_SYNC_END = CORDW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] sx_next_c;
    logic [CORDW-1:0] sy_next_c;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;
    logic             line_c;
    logic             frame_c;

    // Next counter position; every output is decoded from it so all registers agree on one pixel.
    always_comb begin
        sx_next_c = o_sx + CORDW'(1);
        sy_next_c = o_sy;
        if (o_sx == H_LAST) begin
            sx_next_c = '0;
            sy_next_c = (o_sy == V_LAST) ? '0 : o_sy + CORDW'(1);
        end
        de_c    = (sx_next_c < H_ACT) && (sy_next_c < V_ACT);
        hs_c    = ((sx_next_c >= H_SYNC_STA) && (sx_next_c < H_SYNC_END)) ? H_POL : ~H_POL;
        vs_c    = ((sy_next_c >= V_SYNC_STA) && (sy_next_c < V_SYNC_END)) ? V_POL : ~V_POL;
        line_c  = (sx_next_c == '0);
        frame_c = (sx_next_c == '0) && (sy_next_c == '0);
    end

    // Reset parks the counters on the last pixel so the first edge opens a fresh frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sx    <= H_LAST;
            o_sy    <= V_LAST;
            o_de    <= 1'b0;
            o_hs    <= ~H_POL;
            o_vs    <= ~V_POL;
            o_line  <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            o_sx    <= sx_next_c;
            o_sy    <= sy_next_c;
            o_de    <= de_c;
            o_hs    <= hs_c;
            o_vs    <= vs_c;
            o_line  <= line_c;
            o_frame <= frame_c;
        end
    end

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    logic first_frame_seen;

    // The first frame after reset is numbered 0; later frame starts advance the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt      <= '0;
            first_frame_seen <= 1'b0;
        end else if (frame_c) begin
            first_frame_seen <= 1'b1;
            if (first_frame_seen) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_display_timings.sv
// Directed bench: default 640x480 instance for reset/line checks, a reduced instance for frame-level checks.
module tb_display_timings;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic        a_hs, a_vs, a_de, a_line, a_frame;
    logic [15:0] a_sx, a_sy;
    logic        b_hs, b_vs, b_de, b_line, b_frame;
    logic [15:0] b_sx, b_sy;
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    display_timings u_std (
        .i_clk(clk), .i_rst(rst), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de),
        .o_sx(a_sx), .o_sy(a_sy), .o_line(a_line),
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
        .o_frame_cnt(a_cnt),
`endif
        .o_frame(a_frame)
    );

    // Reduced raster: 15 x 8 total (120-cycle frame), hsync active-high on sx 10..12, vsync on sy 5..6.
    display_timings #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CORDW(16)
    ) u_small (
        .i_clk(clk), .i_rst(rst), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
        .o_sx(b_sx), .o_sy(b_sy), .o_line(b_line),
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
        .o_frame_cnt(b_cnt),
`endif
        .o_frame(b_frame)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std_first(input string pfx);
        check({pfx, " std sx"}, 32'(a_sx), 32'd0);
        check({pfx, " std sy"}, 32'(a_sy), 32'd0);
        check({pfx, " std de"}, 32'(a_de), 32'd1);
        check({pfx, " std line"}, 32'(a_line), 32'd1);
        check({pfx, " std frame"}, 32'(a_frame), 32'd1);
        check({pfx, " std hs"}, 32'(a_hs), 32'd1);
        check({pfx, " std vs"}, 32'(a_vs), 32'd1);
        check({pfx, " small sx"}, 32'(b_sx), 32'd0);
        check({pfx, " small sy"}, 32'(b_sy), 32'd0);
        check({pfx, " small frame"}, 32'(b_frame), 32'd1);
        check({pfx, " small hs"}, 32'(b_hs), 32'd0);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, " std sx"}, 32'(a_sx), 32'd799);
        check({pfx, " std sy"}, 32'(a_sy), 32'd524);
        check({pfx, " std de"}, 32'(a_de), 32'd0);
        check({pfx, " std line"}, 32'(a_line), 32'd0);
        check({pfx, " std frame"}, 32'(a_frame), 32'd0);
        check({pfx, " std hs"}, 32'(a_hs), 32'd1);
        check({pfx, " std vs"}, 32'(a_vs), 32'd1);
        check({pfx, " small sx"}, 32'(b_sx), 32'd14);
        check({pfx, " small sy"}, 32'(b_sy), 32'd7);
        check({pfx, " small hs"}, 32'(b_hs), 32'd0);
        check({pfx, " small vs"}, 32'(b_vs), 32'd1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
        check({pfx, " small frame_cnt"}, 32'(b_cnt), 32'd0);
`endif
    endtask

    initial begin
        int de_cnt, hs_low, hs_first, line_cnt;
        int nf, f0, f1, vs_low, vs_sx, vs_sy, de_bad, hs_hi, hs_bad, max_sy;
        int found;
        int cnt_at[3];

        // Reset held across several edges
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        @(negedge clk);
        rst = 1'b0;
        tick();
        check_std_first("first edge");

        // One full line on the standard raster
        de_cnt = 0; hs_low = 0; hs_first = -1; line_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (a_de) de_cnt++;
            if (!a_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(a_sx);
            end
            if (a_line) line_cnt++;
            tick();
        end
        check("line de count", 32'(de_cnt), 32'd640);
        check("line hs low count", 32'(hs_low), 32'd96);
        check("line hs first sx", 32'(hs_first), 32'd656);
        check("line strobes in line", 32'(line_cnt), 32'd1);
        check("next line strobe", 32'(a_line), 32'd1);
        check("next line sx", 32'(a_sx), 32'd0);
        check("next line sy", 32'(a_sy), 32'd1);
        check("next line frame", 32'(a_frame), 32'd0);

        // Mid-frame reset: reach (5,3) on the small raster, then reset without any clock edge
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (b_sx == 16'd5 && b_sy == 16'd3) begin
                found = 1;
                break;
            end
            tick();
        end
        check("reach small (5,3)", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("async reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_std_first("after reset");

        // Two full frames on the small raster
        nf = 0; f0 = -1; f1 = -1; vs_low = 0; vs_sx = -1; vs_sy = -1;
        de_cnt = 0; de_bad = 0; hs_hi = 0; hs_bad = 0; line_cnt = 0; max_sy = 0;
        for (int i = 0; i < 240; i++) begin
            if (b_frame) begin
                if (nf == 0) f0 = i;
                if (nf == 1) f1 = i;
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
                if (nf < 3) cnt_at[nf] = int'(b_cnt);
`endif
                nf++;
            end
            if (!b_vs) begin
                vs_low++;
                if (vs_sx < 0) begin
                    vs_sx = int'(b_sx);
                    vs_sy = int'(b_sy);
                end
            end
            if (b_de) begin
                de_cnt++;
                if (b_sy >= 16'd4) de_bad++;
            end
            if (b_hs) begin
                hs_hi++;
                if (b_sx < 16'd10 || b_sx > 16'd12) hs_bad++;
            end
            if (b_line) line_cnt++;
            if (int'(b_sy) > max_sy) max_sy = int'(b_sy);
            tick();
        end
        check("frame strobes", 32'(nf), 32'd2);
        check("frame period", 32'(f1 - f0), 32'd120);
        check("vs low count", 32'(vs_low), 32'd60);
        check("vs first sx", 32'(vs_sx), 32'd0);
        check("vs first sy", 32'(vs_sy), 32'd5);
        check("frame de count", 32'(de_cnt), 32'd64);
        check("de in blanking lines", 32'(de_bad), 32'd0);
        check("hs high count", 32'(hs_hi), 32'd48);
        check("hs high outside sync", 32'(hs_bad), 32'd0);
        check("line strobes", 32'(line_cnt), 32'd16);
        check("max sy", 32'(max_sy), 32'd7);
        check("third frame strobe", 32'(b_frame), 32'd1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
        cnt_at[2] = int'(b_cnt);
        check("frame_cnt frame 0", 32'(cnt_at[0]), 32'd0);
        check("frame_cnt frame 1", 32'(cnt_at[1]), 32'd1);
        check("frame_cnt frame 2", 32'(cnt_at[2]), 32'd2);
`endif

        // Wrap from the last pixel of the frame
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (b_sx == 16'd14 && b_sy == 16'd7) begin
                found = 1;
                break;
            end
            tick();
        end
        check("reach small last pixel", 32'(found), 32'd1);
        tick();
        check("wrap sx", 32'(b_sx), 32'd0);
        check("wrap sy", 32'(b_sy), 32'd0);
        check("wrap frame", 32'(b_frame), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
